alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Execute-stage consumer of the 6-bit ALU control codes produced by the ALU control decoder. Accepts one operation per valid/ready handshake, computes arithmetic, logic, shift, compare and branch-condition results, and returns them through a registered valid/ready output port. Single-cycle operations complete in one cycle. MUL runs on an iterative shift-add datapath unless the fast-multiply option is compiled in. The pipeline stalls on `in_ready` while a multiply is in flight.

## Interface
- `WIDTH`, 32: operand and result width; only 32 is supported.
- `Clk`  in  1  sole clock, rising edge.
- `Rst`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  operation presented.
- `in_ready`  out  1  unit accepts an operation this cycle.
- `ALUControl`  in  6  operation code, encodings below.
- `A`, `B`  in  32 each  operands (rs, rt or sign-extended immediate).
- `Shamt`  in  5  shift amount for sll/srl.
- `BrSel`  in  1  rt[0]; for code 000001 selects BLTZ (0) or BGEZ (1).
- `out_valid`  out  1  result registered and valid.
- `out_ready`  in  1  downstream consumes the result.
- `Result`  out  32  registered result.
- `Zero`  out  1  Result == 0.
- `BranchTaken`  out  1  branch condition true (branch codes only).
- `Illegal`  out  1  unrecognised code was accepted.

## Operation
- Accept occurs when `in_valid && in_ready`. `in_ready = (state==IDLE) && (!out_valid || out_ready) && Rst`.
- Codes and results:
  - 100000 ADD: A+B, wrap.
  - 100010 SUB: A−B.
  - 011000 MUL: low 32 bits of A×B (sign-agnostic).
  - 100100 AND, 100101 OR, 100111 NOR, 100110 XOR.
  - 000000 sll: B<<Shamt. 000010 srl: B>>Shamt, logical.
  - 101010 slt: signed A<B → 1, otherwise 0.
  - 001000 jr, 000011 JAL: Result=A, where A is the target or link address supplied by the issuer.
- Branch codes set Result=A−B, and `BranchTaken` is computed on signed A/B:
  - 000100 BEQ: A==B.
  - 000101 BNE: A!=B.
  - 000111 BGTZ: A>0.
  - 000110 BLEZ: A<=0.
  - 000001: A<0 when BrSel=0, A>=0 when BrSel=1.
- Any other code: Result=0, Illegal=1, latency 1.
- For non-branch codes, `BranchTaken`=0. For recognised codes, `Illegal`=0.
- FSM states are IDLE and MUL_RUN.
  - IDLE, accept non-MUL: result, flags and `out_valid` registered on the accept edge; stay in IDLE.
  - IDLE, accept MUL: load multiplicand=A, multiplier=B, acc=0, cnt=0; go to MUL_RUN.
  - MUL_RUN, each edge: if multiplier[0], acc += multiplicand (32-bit wrap); multiplicand <<= 1; multiplier >>= 1; cnt++.
  - MUL_RUN, edge where cnt==31: write acc result, set `out_valid`, return to IDLE.
- Output hold: `Result`, `Zero`, `BranchTaken` and `Illegal` stay stable while `out_valid && !out_ready`.
- Output clear: `out_valid` clears on the edge where `out_ready`=1, unless a new accept on that same edge sets it again.
- Simultaneous consume and accept in IDLE is legal and gives back-to-back throughput of 1/cycle.
- Reset (Rst low at an edge):
  - state goes to IDLE; out_valid, Result, Zero, BranchTaken, Illegal and cnt all go to 0.
  - `in_ready` is 0 while Rst is low.
  - A multiply in flight is discarded and produces no `out_valid`.

## Timing
- Non-MUL: accept at edge N → `out_valid` high after edge N. Latency 1; throughput 1/cycle.
- MUL (iterative): accept at edge N → `out_valid` high after edge N+32. `in_ready` is low from edge N until `out_valid` is consumed or `out_ready` is high.
- Output stall: holds indefinitely; no data is lost or overwritten.
- `in_ready` is combinational from state, out_valid, out_ready and Rst. All other outputs are registers.

## Configuration
- `ALU_EXEC_FAST_MUL_EN`
  - Defined: MUL uses a single-cycle `*` operator with latency 1 and throughput 1/cycle. MUL_RUN is never entered.
  - Undefined: iterative 32-cycle shift-add as described above.
  - Results are bit-identical in both builds.

## Test plan
- Reset: hold Rst=0 for 3 cycles with in_valid=1 → out_valid=0, Result=0, in_ready=0; after release in_ready=1.
- ALU ops: ADD 0x7FFFFFFF+1 → Result 0x80000000, Zero=0. SUB 5−5 → Zero=1. slt −1,1 → 1. srl 0x80000000 by 31 → 1. NOR 0,0 → 0xFFFFFFFF.
- Branches: BEQ 3,3 → BranchTaken=1. BGTZ 0 → 0. Code 000001 with A=−4: BrSel=0 → 1, BrSel=1 → 0. Code 111111 → Illegal=1, Result=0.
- MUL: 0xFFFFFFFF×0xFFFFFFFF → 0x00000001 after exactly 32 cycles (1 with the macro). −3×7 → 0xFFFFFFEB. in_ready low throughout the run.
- Backpressure: out_ready=0 for 5 cycles after an ADD → Result held stable, in_ready=0. Then out_ready=1 together with a new accept → back-to-back results with no bubble.
- Reset at MUL cycle 10 → no out_valid; next ADD 1+1 → 2 with latency 1.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake, branch conditions and a multiply unit.
// Build option ALU_EXEC_FAST_MUL_EN selects a single-cycle multiply instead of the 32-cycle shift-add.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       Shamt,
    input  logic             BrSel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             BranchTaken,
    output logic             Illegal
);

    localparam logic [5:0] OP_ADD    = 6'b100000;
    localparam logic [5:0] OP_SUB    = 6'b100010;
    localparam logic [5:0] OP_MUL    = 6'b011000;
    localparam logic [5:0] OP_AND    = 6'b100100;
    localparam logic [5:0] OP_OR     = 6'b100101;
    localparam logic [5:0] OP_NOR    = 6'b100111;
    localparam logic [5:0] OP_XOR    = 6'b100110;
    localparam logic [5:0] OP_SLL    = 6'b000000;
    localparam logic [5:0] OP_SRL    = 6'b000010;
    localparam logic [5:0] OP_SLT    = 6'b101010;
    localparam logic [5:0] OP_JR     = 6'b001000;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_REGIMM = 6'b000001;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             accept_alu;
    logic             start_mul;
    logic             mul_done;
    logic [WIDTH-1:0] mul_res;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic             br_taken;
    logic             illegal;
    logic             a_neg;
    logic             a_zero;

    assign in_ready   = (state == IDLE) && (!out_valid || out_ready) && Rst;
    assign accept     = in_valid && in_ready;
    assign accept_alu = accept && !start_mul;
    assign diff       = A - B;
    assign a_neg      = A[WIDTH-1];
    assign a_zero     = (A == '0);

`ifndef ALU_EXEC_FAST_MUL_EN
    logic             is_mul;
`endif

    // NOTE: combinational blocks use blocking assignments and give every output a default first, so no latch is inferred.
    always_comb begin
        alu_res  = '0;
        br_taken = 1'b0;
        illegal  = 1'b0;
`ifndef ALU_EXEC_FAST_MUL_EN
        is_mul   = 1'b0;
`endif
        case (ALUControl)
            OP_ADD:  alu_res = A + B;
            OP_SUB:  alu_res = diff;
`ifdef ALU_EXEC_FAST_MUL_EN
            OP_MUL:  alu_res = A * B;
`else
            OP_MUL:  is_mul = 1'b1;
`endif
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_NOR:  alu_res = ~(A | B);
            OP_XOR:  alu_res = A ^ B;
            OP_SLL:  alu_res = B << Shamt;
            OP_SRL:  alu_res = B >> Shamt;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_JR, OP_JAL: alu_res = A;
            OP_BEQ: begin
                alu_res  = diff;
                br_taken = (A == B);
            end
            OP_BNE: begin
                alu_res  = diff;
                br_taken = (A != B);
            end
            OP_BGTZ: begin
                alu_res  = diff;
                br_taken = !a_neg && !a_zero;
            end
            OP_BLEZ: begin
                alu_res  = diff;
                br_taken = a_neg || a_zero;
            end
            OP_REGIMM: begin
                // BrSel carries rt[0]: 0 selects BLTZ, 1 selects BGEZ
                alu_res  = diff;
                br_taken = BrSel ? !a_neg : a_neg;
            end
            default: illegal = 1'b1;
        endcase
    end

`ifdef ALU_EXEC_FAST_MUL_EN
    assign start_mul = 1'b0;
    assign mul_done  = 1'b0;
    assign mul_res   = '0;
`else
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [4:0]       cnt;

    assign start_mul = accept && is_mul;
    assign mul_res   = acc + (mplier[0] ? mcand : '0);
    assign mul_done  = (state == MUL_RUN) && (cnt == 5'd31);

    // NOTE: the shift-add operand registers carry no reset; they are reloaded on every MUL accept before use.
    always_ff @(posedge Clk) begin
        if (start_mul) begin
            mcand  <= A;
            mplier <= B;
            acc    <= '0;
        end else if (state == MUL_RUN) begin
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            acc    <= mul_res;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            cnt <= '0;
        end else if (start_mul) begin
            cnt <= '0;
        end else if (state == MUL_RUN) begin
            cnt <= cnt + 5'd1;
        end
    end
`endif

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start_mul) state_next = MUL_RUN;
            MUL_RUN: if (mul_done)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Result and flags only change when a new result is written, so they hold under backpressure
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            out_valid   <= 1'b0;
            Result      <= '0;
            Zero        <= 1'b0;
            BranchTaken <= 1'b0;
            Illegal     <= 1'b0;
        end else if (mul_done) begin
            out_valid   <= 1'b1;
            Result      <= mul_res;
            Zero        <= (mul_res == '0);
            BranchTaken <= 1'b0;
            Illegal     <= 1'b0;
        end else if (accept_alu) begin
            out_valid   <= 1'b1;
            Result      <= alu_res;
            Zero        <= (alu_res == '0);
            BranchTaken <= br_taken;
            Illegal     <= illegal;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, multi-cycle sequences and a
// randomized scoreboard against an arithmetic reference model.
module tb_alu_exec_unit;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  ALUControl;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  Shamt;
    logic        BrSel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;
    logic        Zero;
    logic        BranchTaken;
    logic        Illegal;

    int errors = 0;
    int checks = 0;

`ifdef ALU_EXEC_FAST_MUL_EN
    localparam int MUL_EXTRA_EDGES = 0;
`else
    localparam int MUL_EXTRA_EDGES = 32;
`endif

    alu_exec_unit #(.WIDTH(32)) dut (
        .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready),
        .ALUControl(ALUControl), .A(A), .B(B), .Shamt(Shamt), .BrSel(BrSel),
        .out_valid(out_valid), .out_ready(out_ready), .Result(Result),
        .Zero(Zero), .BranchTaken(BranchTaken), .Illegal(Illegal)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: {Result, Zero, BranchTaken, Illegal} from the operation rules
    function automatic logic [34:0] ref_op(input logic [5:0] code, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh,
                                           input logic br);
        int signed   sa = a;
        int signed   sb = b;
        logic [31:0] r  = 32'h0;
        logic        t  = 1'b0;
        logic        il = 1'b0;
        case (code)
            6'b100000: r = a + b;
            6'b100010: r = a - b;
            6'b011000: r = a * b;
            6'b100100: r = a & b;
            6'b100101: r = a | b;
            6'b100111: r = ~(a | b);
            6'b100110: r = a ^ b;
            6'b000000: r = b << sh;
            6'b000010: r = b >> sh;
            6'b101010: r = (sa < sb) ? 32'd1 : 32'd0;
            6'b001000, 6'b000011: r = a;
            6'b000100: begin r = a - b; t = (sa == sb); end
            6'b000101: begin r = a - b; t = (sa != sb); end
            6'b000111: begin r = a - b; t = (sa > 0);   end
            6'b000110: begin r = a - b; t = (sa <= 0);  end
            6'b000001: begin r = a - b; t = br ? (sa >= 0) : (sa < 0); end
            default:   il = 1'b1;
        endcase
        return {r, (r == 32'h0), t, il};
    endfunction

    typedef struct {
        string       name;
        logic [5:0]  code;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic        br;
        logic [31:0] res;
        logic        zero;
        logic        bt;
        logic        ill;
    } vec_t;

    vec_t vecs[17];

    task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
        int   extra;
        logic rdy_seen;
        ALUControl = 6'b011000; A = a; B = b; Shamt = 5'd0; BrSel = 1'b0;
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        @(posedge Clk); #1;
        in_valid = 1'b0;
        extra    = 0;
        rdy_seen = 1'b0;
        while (!out_valid && extra < 100) begin
            if (in_ready) rdy_seen = 1'b1;
            @(posedge Clk); #1;
            extra++;
        end
        check({name, "_latency"}, extra, MUL_EXTRA_EDGES);
        check({name, "_in_ready_low"}, rdy_seen, 1'b0);
        check({name, "_res"}, {Result, Zero, BranchTaken, Illegal}, {exp, (exp == 32'h0), 2'b00});
    endtask

    task automatic pick_op(output logic [5:0] code, output logic [31:0] a, output logic [31:0] b,
                           output logic [4:0] sh, output logic br);
        logic [5:0] legal[17] = '{6'b100000, 6'b100010, 6'b011000, 6'b100100, 6'b100101,
                                  6'b100111, 6'b100110, 6'b000000, 6'b000010, 6'b101010,
                                  6'b001000, 6'b000011, 6'b000100, 6'b000101, 6'b000111,
                                  6'b000110, 6'b000001};
        code = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal[$urandom_range(0, 16)];
        case ($urandom_range(0, 3))
            0:       a = 32'($urandom_range(0, 4)) - 32'd2;
            default: a = $urandom;
        endcase
        b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
        sh = 5'($urandom);
        br = 1'($urandom);
    endtask

    initial begin
        logic [34:0] exp_q[$];
        logic [34:0] exp;
        logic        seen;
        int          issued;
        logic [5:0]  rc;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [4:0]  rs;
        logic        rbr;

        vecs[0]  = '{"add_ovf",  6'b100000, 32'h7FFFFFFF, 32'h1,        5'd0,  1'b0, 32'h80000000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{"sub_zero", 6'b100010, 32'd5,        32'd5,        5'd0,  1'b0, 32'h0,        1'b1, 1'b0, 1'b0};
        vecs[2]  = '{"slt_neg",  6'b101010, 32'hFFFFFFFF, 32'd1,        5'd0,  1'b0, 32'h1,        1'b0, 1'b0, 1'b0};
        vecs[3]  = '{"srl_31",   6'b000010, 32'h0,        32'h80000000, 5'd31, 1'b0, 32'h1,        1'b0, 1'b0, 1'b0};
        vecs[4]  = '{"nor_0",    6'b100111, 32'h0,        32'h0,        5'd0,  1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{"beq_eq",   6'b000100, 32'd3,        32'd3,        5'd0,  1'b0, 32'h0,        1'b1, 1'b1, 1'b0};
        vecs[6]  = '{"bgtz_0",   6'b000111, 32'h0,        32'h0,        5'd0,  1'b0, 32'h0,        1'b1, 1'b0, 1'b0};
        vecs[7]  = '{"bltz_m4",  6'b000001, 32'hFFFFFFFC, 32'h0,        5'd0,  1'b0, 32'hFFFFFFFC, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{"bgez_m4",  6'b000001, 32'hFFFFFFFC, 32'h0,        5'd0,  1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{"illegal",  6'b111111, 32'd5,        32'd6,        5'd0,  1'b0, 32'h0,        1'b1, 1'b0, 1'b1};
        vecs[10] = '{"sll_4",    6'b000000, 32'h0,        32'h1,        5'd4,  1'b0, 32'h10,       1'b0, 1'b0, 1'b0};
        vecs[11] = '{"jr",       6'b001000, 32'h00400020, 32'h1234,     5'd0,  1'b0, 32'h00400020, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{"jal",      6'b000011, 32'h00400008, 32'h0,        5'd0,  1'b0, 32'h00400008, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{"blez_m1",  6'b000110, 32'hFFFFFFFF, 32'h0,        5'd0,  1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{"bne_1_2",  6'b000101, 32'd1,        32'd2,        5'd0,  1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{"xor",      6'b100110, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  1'b0, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{"and",      6'b100100, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  1'b0, 32'hF000F000, 1'b0, 1'b0, 1'b0};

        // Reset held for three edges with an operation presented
        Rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        ALUControl = 6'b100000; A = 32'd1; B = 32'd2; Shamt = 5'd0; BrSel = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", {Result, Zero, BranchTaken, Illegal}, 35'h0);
        check("rst_in_ready", in_ready, 1'b0);
        in_valid = 1'b0;
        Rst = 1'b1;
        #1;
        check("rst_release_in_ready", in_ready, 1'b1);

        // Directed table, issued back-to-back with out_ready high
        foreach (vecs[i]) begin
            ALUControl = vecs[i].code; A = vecs[i].a; B = vecs[i].b;
            Shamt = vecs[i].sh; BrSel = vecs[i].br; in_valid = 1'b1;
            @(posedge Clk); #1;
            check({vecs[i].name, "_valid"}, out_valid, 1'b1);
            check(vecs[i].name, {Result, Zero, BranchTaken, Illegal},
                  {vecs[i].res, vecs[i].zero, vecs[i].bt, vecs[i].ill});
        end
        in_valid = 1'b0;
        @(posedge Clk); #1;
        check("idle_drain", out_valid, 1'b0);

        run_mul("mul_ff", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
        run_mul("mul_m3x7", 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB);
        @(posedge Clk); #1;

        // Backpressure: hold an ADD result for 5 cycles, then consume and accept together
        ALUControl = 6'b100000; A = 32'd2; B = 32'd3; out_ready = 1'b0; in_valid = 1'b1;
        @(posedge Clk); #1;
        A = 32'd10; B = 32'd20;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (in_ready || !out_valid || Result !== 32'd5) seen = 1'b1;
            @(posedge Clk); #1;
        end
        check("bp_hold", seen, 1'b0);
        check("bp_held_result", {out_valid, Result}, {1'b1, 32'd5});
        out_ready = 1'b1;
        #1;
        check("bp_ready_on_consume", in_ready, 1'b1);
        @(posedge Clk); #1;
        check("bp_b2b_1", {out_valid, Result}, {1'b1, 32'd30});
        A = 32'd100; B = 32'd1;
        @(posedge Clk); #1;
        check("bp_b2b_2", {out_valid, Result}, {1'b1, 32'd101});
        in_valid = 1'b0;
        @(posedge Clk); #1;

        // Reset during a multiply discards it
        ALUControl = 6'b011000; A = 32'd6; B = 32'd7; in_valid = 1'b1;
        @(posedge Clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge Clk);
        #1;
        Rst = 1'b0;
        @(posedge Clk); #1;
        Rst = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid) seen = 1'b1;
            @(posedge Clk); #1;
        end
        check("rst_mul_no_out", seen, 1'b0);
        ALUControl = 6'b100000; A = 32'd1; B = 32'd1; in_valid = 1'b1;
        @(posedge Clk); #1;
        in_valid = 1'b0;
        check("post_rst_add", {out_valid, Result}, {1'b1, 32'd2});
        @(posedge Clk); #1;

        // Randomized traffic with random backpressure against the scoreboard
        issued = 0;
        for (int cyc = 0; cyc < 6000 && issued < 200; cyc++) begin
            pick_op(rc, ra, rb, rs, rbr);
            ALUControl = rc; A = ra; B = rb; Shamt = rs; BrSel = rbr;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_op(rc, ra, rb, rs, rbr));
                issued++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rnd_unexpected: out_valid with no outstanding operation");
                end else begin
                    exp = exp_q.pop_front();
                    check("rnd", {Result, Zero, BranchTaken, Illegal}, exp);
                end
            end
            @(posedge Clk); #1;
        end
        check("rnd_issued", issued, 200);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && exp_q.size() != 0; cyc++) begin
            if (out_valid) begin
                exp = exp_q.pop_front();
                check("rnd_drain", {Result, Zero, BranchTaken, Illegal}, exp);
            end
            @(posedge Clk); #1;
        end
        check("rnd_all_consumed", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
